// File: rtl/uart_rx_framer_pkg.sv
// Shared UART receive definitions: state encoding, oversampling constants
// and the baud tick divisor calculation (also used by the TX side).
package uart_rx_framer_pkg;

    localparam int OVERSAMPLE = 16;
    localparam int HALF_BIT   = 8;

    typedef enum logic [2:0] {
        ST_WAIT_IDLE = 3'd0,
        ST_IDLE      = 3'd1,
        ST_START     = 3'd2,
        ST_DATA      = 3'd3,
        ST_STOP      = 3'd4
    } rx_state_t;

    // Rounded-to-nearest divisor from system clock to the oversample tick, never below 1.
    function automatic int tick_div_calc(input int clk_hz, input int baud);
        longint den;
        longint q;
        den = longint'(baud) * longint'(OVERSAMPLE);
        q   = (longint'(clk_hz) + den / 2) / den;
        return (q < 1) ? 1 : int'(q);
    endfunction

endpackage

// File: rtl/uart_rx_framer_if.sv
// Serial pin, byte hand-off and status signals between the RX framer and its consumer.
interface uart_rx_framer_if;

    logic       UartRxWire;
    logic       ClearErr;
    logic       RxReady;
    logic [7:0] RxData;
    logic       RxValid;
    logic       FrameErr;
    logic       Overrun;
    logic       Busy;

    modport master (
        input  UartRxWire, ClearErr, RxReady,
        output RxData, RxValid, FrameErr, Overrun, Busy
    );

    modport slave (
        output UartRxWire, ClearErr, RxReady,
        input  RxData, RxValid, FrameErr, Overrun, Busy
    );

endinterface

// File: rtl/uart_rx_framer_baud_tick.sv
// Free-running down-counter producing a one-cycle oversample tick every TICK_DIV clocks.
module uart_baud_tick #(
    parameter int TICK_DIV = 27
) (
    input  logic clk_sys,
    input  logic rst_b,
    output logic tick
);

    localparam int CW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
    localparam logic [CW-1:0] RELOAD = CW'(TICK_DIV - 1);

    logic [CW-1:0] cnt;

    always_ff @(posedge clk_sys) begin
        if (!rst_b) begin
            cnt <= '0;
        end else if (cnt == '0) begin
            cnt <= RELOAD;
        end else begin
            cnt <= cnt - CW'(1);
        end
    end

    assign tick = (cnt == '0);

endmodule

// File: rtl/uart_rx_framer.sv
// 8N1 UART receiver: two-flop sync, 16x oversampled framing, single-entry output buffer.
//
// state        | meaning
// WAIT_IDLE    | waiting for 16 consecutive idle-high ticks before trusting a start edge
// IDLE         | line idle, watching for a synced 1->0 transition
// START        | half a bit into the start bit, confirming it is still low
// DATA         | sampling 8 data bits LSB first at bit centres
// STOP         | sampling the stop bit, delivering or flagging the byte
module uart_rx_framer
    import uart_rx_framer_pkg::*;
#(
    parameter int CLK_HZ = 50000000,
    parameter int BAUD   = 115200
) (
    input  logic             Clk,
    input  logic             ResetN,
    uart_rx_framer_if.master bus
);

    localparam int TICK_DIV = tick_div_calc(CLK_HZ, BAUD);
    localparam logic [3:0] PH_FULL = 4'(OVERSAMPLE - 1);
    localparam logic [3:0] PH_HALF = 4'(HALF_BIT - 1);

    rx_state_t  state, state_nxt;
    logic       tick;
    logic       sync1, sync2, rx_prev;
    logic [3:0] ph_cnt;
    logic [2:0] bit_cnt;
    logic [7:0] shreg;
    logic [7:0] data_q;
    logic       valid_q, ferr_q, ovr_q;
    logic       ph_zero, fall_det, sample;
    logic       start_ok, shift_en, stop_ok, stop_bad, busy;

    uart_baud_tick #(.TICK_DIV(TICK_DIV)) u_tick (
        .clk_sys (Clk),
        .rst_b   (ResetN),
        .tick    (tick)
    );

    always_ff @(posedge Clk) begin
        if (!ResetN) begin
            sync1   <= 1'b1;
            sync2   <= 1'b1;
            rx_prev <= 1'b1;
        end else begin
            sync1   <= bus.UartRxWire;
            sync2   <= sync1;
            rx_prev <= sync2;
        end
    end

    assign ph_zero  = (ph_cnt == 4'd0);
    assign fall_det = rx_prev & ~sync2;
    assign sample   = tick & ph_zero;

    always_ff @(posedge Clk) begin
        if (!ResetN) state <= ST_WAIT_IDLE;
        else         state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            ST_WAIT_IDLE: if (sample && sync2)               state_nxt = ST_IDLE;
            ST_IDLE:      if (fall_det)                      state_nxt = ST_START;
            ST_START:     if (sample)                        state_nxt = sync2 ? ST_IDLE : ST_DATA;
            ST_DATA:      if (sample && bit_cnt == 3'd0)     state_nxt = ST_STOP;
            ST_STOP:      if (sample)                        state_nxt = sync2 ? ST_IDLE : ST_WAIT_IDLE;
            default:                                         state_nxt = ST_WAIT_IDLE;
        endcase
    end

    always_comb begin
        busy     = (state != ST_IDLE);
        start_ok = 1'b0;
        shift_en = 1'b0;
        stop_ok  = 1'b0;
        stop_bad = 1'b0;
        case (state)
            ST_START: start_ok = sample & ~sync2;
            ST_DATA:  shift_en = sample;
            ST_STOP: begin
                stop_ok  = sample & sync2;
                stop_bad = sample & ~sync2;
            end
            default: ;
        endcase
    end

    // Phase counter: preloaded to a half bit while idle so the start bit is checked at its centre.
    always_ff @(posedge Clk) begin
        if (!ResetN) begin
            ph_cnt  <= PH_FULL;
            bit_cnt <= 3'd0;
            shreg   <= 8'h00;
        end else begin
            case (state)
                ST_IDLE: ph_cnt <= PH_HALF;
                ST_WAIT_IDLE: begin
                    if (tick) begin
                        if (!sync2)        ph_cnt <= PH_FULL;
                        else if (!ph_zero) ph_cnt <= ph_cnt - 4'd1;
                    end
                end
                default: if (tick) ph_cnt <= ph_zero ? PH_FULL : ph_cnt - 4'd1;
            endcase
            if (start_ok)      bit_cnt <= 3'd7;
            else if (shift_en) bit_cnt <= bit_cnt - 3'd1;
            if (shift_en)      shreg <= {sync2, shreg[7:1]};
        end
    end

    // A hand-off on the same edge as a new byte frees the buffer, so that is a load, not an overrun.
    always_ff @(posedge Clk) begin
        if (!ResetN) begin
            data_q  <= 8'h00;
            valid_q <= 1'b0;
            ferr_q  <= 1'b0;
            ovr_q   <= 1'b0;
        end else begin
            ferr_q <= stop_bad;
            if (stop_ok && (!valid_q || bus.RxReady)) begin
                data_q  <= shreg;
                valid_q <= 1'b1;
            end else if (valid_q && bus.RxReady) begin
                valid_q <= 1'b0;
            end
            if (stop_ok && valid_q && !bus.RxReady) ovr_q <= 1'b1;
            else if (bus.ClearErr)                  ovr_q <= 1'b0;
        end
    end

    assign bus.RxData   = data_q;
    assign bus.RxValid  = valid_q;
    assign bus.FrameErr = ferr_q;
    assign bus.Overrun  = ovr_q;
    assign bus.Busy     = busy;

endmodule

// File: tb/tb_uart_rx_framer.sv
// Scoreboard bench for uart_rx_framer: frames are built bit by bit on the pin,
// expected bytes queued by a buffer-occupancy model and popped on each hand-off.
module tb_uart_rx_framer;

    localparam int CLK_HZ   = 1600000;
    localparam int BAUD     = 100000;
    localparam int BIT_CLKS = 16;

    typedef struct {
        logic [7:0] data;
        int         fall_cyc;
        bit         chk_lat;
    } exp_t;

    logic Clk = 1'b0;
    logic ResetN = 1'b0;

    uart_rx_framer_if bus ();

    uart_rx_framer #(.CLK_HZ(CLK_HZ), .BAUD(BAUD)) dut (
        .Clk    (Clk),
        .ResetN (ResetN),
        .bus    (bus)
    );

    always #5 Clk = ~Clk;

    exp_t exp_q[$];
    int   rise_q[$];
    int   cyc = 0;
    int   n_vec = 0;
    int   n_err = 0;
    int   fe_cnt = 0;
    int   fe_exp = 0;
    bit   model_full = 1'b0;
    bit   ovr_exp = 1'b0;
    bit   drop_chk = 1'b0;
    bit   fe_prev = 1'b0;

    always @(posedge Clk) cyc <= cyc + 1;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h want %0h", name, act, exp);
        end
    endtask

    task automatic step(input int n);
        repeat (n) begin
            @(posedge Clk);
            #1;
        end
    endtask

    // Reference model: a good frame is delivered unless the buffer still holds an unaccepted byte.
    task automatic send(input logic [7:0] b, input logic stop_bit);
        logic [9:0] frame;
        exp_t e;
        if (stop_bit) begin
            if (model_full && !bus.RxReady) begin
                ovr_exp = 1'b1;
            end else begin
                e.data     = b;
                e.fall_cyc = cyc;
                e.chk_lat  = bus.RxReady;
                exp_q.push_back(e);
                model_full = !bus.RxReady;
            end
        end else begin
            fe_exp++;
        end
        frame = {stop_bit, b, 1'b0};
        for (int i = 0; i < 10; i++) begin
            bus.UartRxWire = frame[i];
            step(BIT_CLKS);
        end
        bus.UartRxWire = 1'b1;
    endtask

    always @(negedge Clk) begin
        exp_t e;
        int   lat;
        if (ResetN) begin
            if (drop_chk) begin
                check("valid_drop", bus.RxValid, 0);
                drop_chk = 1'b0;
            end
            if (bus.RxValid && bus.RxReady) begin
                if (exp_q.size() == 0) begin
                    n_vec++;
                    n_err++;
                    $display("FAIL unexpected_byte: got %02h want none", bus.RxData);
                end else begin
                    e = exp_q.pop_front();
                    check("rx_data", bus.RxData, e.data);
                    if (e.chk_lat) begin
                        lat = cyc - e.fall_cyc;
                        n_vec++;
                        if (lat < 154 || lat > 156) begin
                            n_err++;
                            $display("FAIL latency: got %0d clocks want 155+-1", lat);
                        end
                    end
                end
                rise_q.push_back(cyc);
                model_full = 1'b0;
                drop_chk   = 1'b1;
            end
            if (bus.FrameErr) begin
                fe_cnt++;
                if (fe_prev) begin
                    n_vec++;
                    n_err++;
                    $display("FAIL frame_err_width: got 2+ cycles want 1");
                end
            end
            fe_prev = bus.FrameErr;
        end
    end

    initial begin
        #400000;
        $display("FAIL watchdog: got timeout want completion");
        $fatal(1, "bench timed out");
    end

    initial begin
        int k;
        int t;
        bus.UartRxWire = 1'b1;
        bus.ClearErr   = 1'b0;
        bus.RxReady    = 1'b1;
        ResetN         = 1'b0;
        step(3);
        check("rst_data", bus.RxData, 0);
        check("rst_valid", bus.RxValid, 0);
        check("rst_ferr", bus.FrameErr, 0);
        check("rst_ovr", bus.Overrun, 0);
        check("rst_busy", bus.Busy, 1);
        ResetN = 1'b1;
        step(20);
        check("idle_busy", bus.Busy, 0);

        // single byte
        send(8'hA5, 1'b1);
        step(4);
        check("single_drained", exp_q.size(), 0);
        check("single_ovr", bus.Overrun, 0);
        check("single_ferr_cnt", fe_cnt, fe_exp);

        // glitch shorter than half a bit
        bus.UartRxWire = 1'b0;
        step(4);
        check("glitch_busy_set", bus.Busy, 1);
        bus.UartRxWire = 1'b1;
        k = 0;
        while (bus.Busy && k < 12) begin
            step(1);
            k++;
        end
        check("glitch_busy_clear", bus.Busy, 0);
        check("glitch_ferr_cnt", fe_cnt, fe_exp);
        step(10);

        // framing error then recovery after 16 idle clocks
        send(8'h3C, 1'b0);
        step(16);
        send(8'h55, 1'b1);
        step(4);
        check("ferr_cnt", fe_cnt, fe_exp);
        check("ferr_drained", exp_q.size(), 0);

        // overrun with consumer stalled
        bus.RxReady = 1'b0;
        send(8'h11, 1'b1);
        send(8'h22, 1'b1);
        step(2);
        check("ovr_valid_held", bus.RxValid, 1);
        check("ovr_data_held", bus.RxData, 8'h11);
        check("ovr_set", bus.Overrun, ovr_exp);
        bus.RxReady = 1'b1;
        step(1);
        bus.RxReady = 1'b0;
        step(1);
        check("ovr_after_take_valid", bus.RxValid, 0);
        check("ovr_sticky", bus.Overrun, ovr_exp);
        bus.ClearErr = 1'b1;
        step(1);
        bus.ClearErr = 1'b0;
        ovr_exp = 1'b0;
        check("ovr_cleared", bus.Overrun, ovr_exp);
        bus.RxReady = 1'b1;
        check("ovr_drained", exp_q.size(), 0);
        step(10);

        // reset during data bit 3 with the line held low through the frame
        bus.UartRxWire = 1'b0;
        step(72);
        ResetN = 1'b0;
        step(1);
        ResetN = 1'b1;
        step(160 - 73);
        bus.UartRxWire = 1'b1;
        step(16);
        send(8'h7E, 1'b1);
        step(4);
        check("rst_mid_drained", exp_q.size(), 0);
        check("rst_mid_ferr_cnt", fe_cnt, fe_exp);

        // back-to-back frames, single stop bit
        rise_q.delete();
        send(8'h01, 1'b1);
        send(8'h80, 1'b1);
        step(4);
        check("b2b_count", rise_q.size(), 2);
        check("b2b_spacing", (rise_q.size() == 2) ? rise_q[1] - rise_q[0] : 0, 160);

        // random bytes with random idle gaps
        for (int i = 0; i < 12; i++) begin
            step($urandom_range(0, 6));
            send(8'($urandom), 1'b1);
        end

        t = 0;
        while (exp_q.size() != 0 && t < 400) begin
            step(1);
            t++;
        end
        step(4);
        check("final_queue_empty", exp_q.size(), 0);
        check("final_ferr_cnt", fe_cnt, fe_exp);
        check("final_ovr", bus.Overrun, ovr_exp);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
